// File: rtl/rdback_flow_if.sv
// rdback_flow_if: scheduler, read-return and FIFO-pop signals of the readback credit controller.
interface rdback_flow_if #(
    parameter int CNT_W = 10
);
    logic             enable;
    logic             drain_req;
    logic             err_clr;
    logic             rd_req;
    logic             rd_gnt;
    logic             dfi_rddata_valid;
    logic             fifo_rd_en;
    logic [CNT_W-1:0] credits;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] occupancy;
    logic             busy;
    logic             stall;
    logic             timeout_err;
    logic             proto_err;

    modport master (
        output enable, drain_req, err_clr, rd_req, dfi_rddata_valid, fifo_rd_en,
        input  rd_gnt, credits, inflight, occupancy, busy, stall, timeout_err, proto_err
    );

    modport slave (
        input  enable, drain_req, err_clr, rd_req, dfi_rddata_valid, fifo_rd_en,
        output rd_gnt, credits, inflight, occupancy, busy, stall, timeout_err, proto_err
    );
endinterface

// File: rtl/rdback_flow_ctrl.sv
// rdback_flow_ctrl: credit-based read issue gating so the readback FIFO can never overflow,
// with detection of missing (timeout) and unexpected (protocol) return data.
module rdback_flow_ctrl #(
    parameter int FIFO_DEPTH = 512,
    parameter int CNT_W      = 10,
    parameter int RD_TIMEOUT = 255,
    parameter int TO_W       = 8
) (
    input logic          clk,
    input logic          rst,
    rdback_flow_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERROR} state_t;

    localparam logic [CNT_W-1:0] DEPTH  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W:0]   LIMIT  = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  TO_LIM = TO_W'(RD_TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] credits;
    logic [CNT_W-1:0] inf_nxt;
    logic [CNT_W-1:0] occ_nxt;
    logic [CNT_W-1:0] cred_nxt;
    logic [CNT_W:0]   used;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_nxt;
    logic             active;
    logic             gnt;
    logic             ret;
    logic             push;
    logic             pop;
    logic             clr;
    logic             proto_hit;
    logic             to_hit;
    logic             run_stall;
    logic             stall;
    logic             timeout_err;
    logic             proto_err;

    always_comb begin
        active    = state == RUN || state == DRAIN;
        gnt       = bus.rd_req && state == RUN && credits != '0;
        ret       = bus.dfi_rddata_valid && inflight != '0;
        push      = bus.dfi_rddata_valid && occupancy < DEPTH;
        pop       = bus.fifo_rd_en && occupancy != '0;
        clr       = state == ERROR && bus.err_clr;
        inf_nxt   = clr ? '0 : inflight + CNT_W'(gnt) - CNT_W'(ret);
        occ_nxt   = occupancy + CNT_W'(push) - CNT_W'(pop);
        // stray returns can push the sum past the depth; credits floor at zero
        used      = {1'b0, occ_nxt} + {1'b0, inf_nxt};
        cred_nxt  = used >= LIMIT ? '0 : CNT_W'(LIMIT - used);
        to_nxt    = (!active || inflight == '0 || bus.dfi_rddata_valid) ? '0
                  : (to_cnt == '1 ? to_cnt : to_cnt + TO_W'(1));
        proto_hit = active && bus.dfi_rddata_valid && (inflight == '0 || occupancy == DEPTH);
        to_hit    = active && to_nxt == TO_LIM;
        run_stall = cred_nxt == '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            inflight    <= '0;
            occupancy   <= '0;
            credits     <= DEPTH;
            to_cnt      <= '0;
            stall       <= 1'b0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            inflight  <= inf_nxt;
            occupancy <= occ_nxt;
            credits   <= cred_nxt;
            to_cnt    <= to_nxt;
            stall     <= 1'b0;
            if (active && (proto_hit || to_hit)) begin
                state       <= ERROR;
                proto_err   <= proto_err | proto_hit;
                timeout_err <= timeout_err | to_hit;
            end else begin
                case (state)
                    IDLE: if (bus.enable) begin
                        state <= RUN;
                        stall <= run_stall;
                    end
                    RUN: if (bus.drain_req || !bus.enable) state <= DRAIN;
                         else stall <= run_stall;
                    DRAIN: if (inf_nxt == '0) state <= IDLE;
                    ERROR: if (bus.err_clr) begin
                        state       <= IDLE;
                        proto_err   <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rd_gnt      = gnt;
    assign bus.credits     = credits;
    assign bus.inflight    = inflight;
    assign bus.occupancy   = occupancy;
    assign bus.busy        = state != IDLE;
    assign bus.stall       = stall;
    assign bus.timeout_err = timeout_err;
    assign bus.proto_err   = proto_err;
endmodule

// File: tb/tb_rdback_flow_ctrl.sv
// tb_rdback_flow_ctrl: directed scenarios plus random traffic against a cycle-level
// occupancy/in-flight model of the readback credit controller.
module tb_rdback_flow_ctrl;
    localparam int DEPTH = 512;
    localparam int TMO   = 255;
    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_ERR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rdback_flow_if #(.CNT_W(10)) bus();

    rdback_flow_ctrl #(
        .FIFO_DEPTH(DEPTH),
        .CNT_W(10),
        .RD_TIMEOUT(TMO),
        .TO_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int gnts   = 0;
    int m_st, m_inf, m_occ, m_idle;
    bit m_terr, m_perr;

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int m_cred();
        int c;
        c = DEPTH - m_occ - m_inf;
        return c < 0 ? 0 : c;
    endfunction

    task automatic check_outs();
        check("credits", int'(bus.credits), m_cred());
        check("inflight", int'(bus.inflight), m_inf);
        check("occupancy", int'(bus.occupancy), m_occ);
        check("busy", int'(bus.busy), int'(m_st != S_IDLE));
        check("stall", int'(bus.stall), int'(m_st == S_RUN && m_cred() == 0));
        check("timeout_err", int'(bus.timeout_err), int'(m_terr));
        check("proto_err", int'(bus.proto_err), int'(m_perr));
    endtask

    task automatic drive(bit en, bit dr, bit clr, bit req, bit val, bit pop);
        bus.enable           = en;
        bus.drain_req        = dr;
        bus.err_clr          = clr;
        bus.rd_req           = req;
        bus.dfi_rddata_valid = val;
        bus.fifo_rd_en       = pop;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 0, 1, 0, 0);
        @(posedge clk);
        @(posedge clk);
        m_st = S_IDLE; m_inf = 0; m_occ = 0; m_idle = 0; m_terr = 0; m_perr = 0;
        #1 check_outs();
        check("rst_gnt", int'(bus.rd_gnt), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    // One clock of stimulus; the model advances by the documented rules, then the DUT is compared.
    task automatic cyc(bit en, bit dr, bit clr, bit req, bit val, bit pop);
        bit g, act, perr, terr;
        int ni, no, nt, ns;
        @(negedge clk);
        drive(en, dr, clr, req, val, pop);
        g = req && m_st == S_RUN && m_cred() > 0;
        #1 check("rd_gnt", int'(bus.rd_gnt), int'(g));
        gnts += int'(bus.rd_gnt);
        act  = m_st == S_RUN || m_st == S_DRAIN;
        perr = act && val && (m_inf == 0 || m_occ == DEPTH);
        ni   = m_inf + int'(g) - int'(val && m_inf > 0);
        no   = m_occ + int'(val && m_occ < DEPTH) - int'(pop && m_occ > 0);
        nt   = (!act || m_inf == 0 || val) ? 0 : m_idle + 1;
        terr = act && nt >= TMO;
        ns   = m_st;
        if (m_st == S_IDLE) ns = en ? S_RUN : S_IDLE;
        else if (m_st == S_ERR) begin
            if (clr) begin
                ns = S_IDLE; ni = 0; m_terr = 0; m_perr = 0;
            end
        end else if (perr || terr) begin
            ns = S_ERR; m_perr |= perr; m_terr |= terr;
        end else if (m_st == S_RUN) ns = (dr || !en) ? S_DRAIN : S_RUN;
        else ns = ni == 0 ? S_IDLE : S_DRAIN;
        m_inf = ni; m_occ = no; m_idle = nt; m_st = ns;
        @(posedge clk);
        #1 check_outs();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        // fill all credits; sparse returns keep the timeout quiet without changing the credit total
        do_reset();
        gnts = 0;
        for (int i = 0; i < 600; i++) cyc(1, 0, 0, 1, i % 200 == 199, 0);
        check("t1_gnts", gnts, 512);
        check("t1_credits", int'(bus.credits), 0);
        check("t1_stall", int'(bus.stall), 1);
        repeat (509) cyc(1, 0, 0, 0, 1, 0);
        check("t3_occ_full", int'(bus.occupancy), 512);
        gnts = 0;
        cyc(1, 0, 0, 1, 0, 1);
        check("t3_credit_back", int'(bus.credits), 1);
        cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        check("t3_one_more", gnts, 1);

        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        repeat (5) cyc(1, 0, 0, 1, 0, 0);
        repeat (10) cyc(1, 0, 0, 1, 1, 0);
        check("t2_inflight", int'(bus.inflight), 5);
        check("t2_occ", int'(bus.occupancy), 10);

        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 1, 0, 0);
        repeat (252) cyc(1, 0, 0, 0, 0, 0);
        check("t4_pre_to", int'(bus.timeout_err), 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("t4_to", int'(bus.timeout_err), 1);
        cyc(0, 0, 1, 0, 0, 0);
        check("t4_clr_busy", int'(bus.busy), 0);
        check("t4_clr_inf", int'(bus.inflight), 0);

        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        gnts = 0;
        repeat (5) cyc(1, 0, 0, 1, 0, 0);
        check("t5_perr", int'(bus.proto_err), 1);
        check("t5_no_gnt", gnts, 0);
        cyc(0, 0, 1, 0, 0, 0);

        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        gnts = 0;
        repeat (4) cyc(0, 0, 0, 1, 1, 0);
        check("t6_no_gnt", gnts, 0);
        check("t6_busy", int'(bus.busy), 0);
        cyc(1, 0, 0, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 1, 1);
        do_reset();
        check("t6_rst_inf", int'(bus.inflight), 0);
        check("t6_rst_occ", int'(bus.occupancy), 0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else cyc($urandom_range(0, 19) != 0, $urandom_range(0, 49) == 0,
                     $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                     m_inf > 0 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 39) == 0,
                     $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
